// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI transfer arbiter.
// ID_W is sized for the largest supported requester count so every instance can share it.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BUSY = 3'd1,
        WAIT_DONE = 3'd2,
        RESP      = 3'd3,
        ABORT     = 3'd4
    } state_t;

    localparam int MAX_REQ = 8;
    localparam int ID_W    = $clog2(MAX_REQ);

    localparam int              WD_W   = 20;
    localparam logic [WD_W-1:0] WD_MAX = '1;

endpackage

// File: rtl/spi_xfer_arbiter_rr_pick.sv
// Combinational round-robin picker.
// It returns the first set request found searching upward from rr_ptr, wrapping around.
module rr_pick
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    id,
    output logic [NUM_REQ-1:0] onehot,
    output logic               any
);

    int idx;

    // Scan from the farthest offset down, so the closest hit to rr_ptr is written last.
    always_comb begin
        id     = '0;
        onehot = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                id          = ID_W'(idx);
                onehot      = '0;
                onehot[idx] = 1'b1;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one spi_master between several requesters: round-robin arbitration,
// master launch, completion tracking and a per-wait-state watchdog.
module spi_xfer_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 8,
    parameter int SLV_IDX_W      = 3,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*SLV_IDX_W-1:0]    req_slv,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_tx_data,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              done,
    output logic [NUM_REQ-1:0]              err,
    output logic [DATA_WIDTH-1:0]           rsp_rx_data,
    output logic                            m_start,
    output logic [DATA_WIDTH-1:0]           m_tx_data,
    output logic [NUM_SLAVES-1:0]           m_ss_sel,
    input  logic                            m_busy,
    input  logic                            m_irq,
    input  logic [DATA_WIDTH-1:0]           m_rx_data
);

    state_t                 state, state_next;
    logic [ID_W-1:0]        rr_ptr, cur_id, pick_id, next_ptr;
    logic [NUM_REQ-1:0]     cur_onehot, pick_onehot;
    logic                   pick_any, pick_ok, slv_bad;
    logic [SLV_IDX_W-1:0]   pick_slv;
    logic [DATA_WIDTH-1:0]  pick_tx;
    logic [NUM_SLAVES-1:0]  pick_ss;
    logic [WD_W-1:0]        wd;
    logic                   wd_expired;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .id     (pick_id),
        .onehot (pick_onehot),
        .any    (pick_any)
    );

    assign pick_slv   = req_slv[int'(pick_id) * SLV_IDX_W +: SLV_IDX_W];
    assign pick_tx    = req_tx_data[int'(pick_id) * DATA_WIDTH +: DATA_WIDTH];
    assign pick_ok    = 32'(pick_slv) < 32'(NUM_SLAVES);
    assign wd_expired = 32'(wd) >= 32'(TIMEOUT_CYCLES);
    assign next_ptr   = (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;

    // An out-of-range index decodes to no select line at all.
    always_comb begin
        pick_ss = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            pick_ss[i] = (32'(pick_slv) == 32'(i));
    end

    always_comb begin
        state_next = state;
        gnt        = '0;
        done       = '0;
        err        = '0;
        case (state)
            IDLE: begin
                if (pick_any && !m_busy) state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                gnt = cur_onehot;
                if (slv_bad)         state_next = ABORT;
                else if (m_irq)      state_next = RESP;
                else if (m_busy)     state_next = WAIT_DONE;
                else if (wd_expired) state_next = ABORT;
            end
            WAIT_DONE: begin
                gnt = cur_onehot;
                // Completion is checked first so it beats a simultaneous watchdog expiry.
                if (m_irq || !m_busy) state_next = RESP;
                else if (wd_expired)  state_next = ABORT;
            end
            RESP: begin
                gnt        = cur_onehot;
                done       = cur_onehot;
                state_next = IDLE;
            end
            ABORT: begin
                gnt        = cur_onehot;
                done       = cur_onehot;
                err        = cur_onehot;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cur_id      <= '0;
            cur_onehot  <= '0;
            slv_bad     <= 1'b0;
            wd          <= '0;
            m_start     <= 1'b0;
            m_tx_data   <= '0;
            m_ss_sel    <= '0;
            rsp_rx_data <= '0;
        end else begin
            state   <= state_next;
            m_start <= 1'b0;
            if (state_next != state)
                wd <= '0;
            else if (wd != WD_MAX)
                wd <= wd + 1'b1;
            case (state)
                IDLE: begin
                    if (state_next == WAIT_BUSY) begin
                        cur_id     <= pick_id;
                        cur_onehot <= pick_onehot;
                        slv_bad    <= !pick_ok;
                        m_tx_data  <= pick_tx;
                        m_ss_sel   <= pick_ss;
                        m_start    <= pick_ok;
                    end
                end
                WAIT_BUSY, WAIT_DONE: begin
                    if (state_next == RESP)
                        rsp_rx_data <= m_rx_data;
                    else if (state_next == ABORT)
                        rsp_rx_data <= '0;
                end
                RESP, ABORT: begin
                    m_tx_data <= '0;
                    m_ss_sel  <= '0;
                    rr_ptr    <= next_ptr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter with a small behavioural spi_master model.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_spi_xfer_arbiter;

    localparam int NUM_REQ        = 4;
    localparam int DATA_WIDTH     = 32;
    localparam int NUM_SLAVES     = 4;
    localparam int SLV_IDX_W      = 3;
    localparam int TIMEOUT_CYCLES = 16;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic [NUM_REQ-1:0]            req = '0;
    logic [NUM_REQ*SLV_IDX_W-1:0]  req_slv = '0;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_tx_data = '0;
    logic [NUM_REQ-1:0]            gnt, done, err;
    logic [DATA_WIDTH-1:0]         rsp_rx_data, m_tx_data;
    logic                          m_start;
    logic [NUM_SLAVES-1:0]         m_ss_sel;
    logic                          m_busy = 1'b0;
    logic                          m_irq = 1'b0;
    logic [DATA_WIDTH-1:0]         m_rx_data = '0;

    int check_count = 0;
    int error_count = 0;

    int          busy_delay = 3;
    int          irq_delay  = 14;
    logic        never_busy = 1'b0;
    logic [31:0] rx_word    = '0;
    logic        m_active   = 1'b0;
    int          m_cnt      = 0;
    int          start_count = 0;
    int          gnt_faults  = 0;
    int          cyc;

    spi_xfer_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .DATA_WIDTH     (DATA_WIDTH),
        .NUM_SLAVES     (NUM_SLAVES),
        .SLV_IDX_W      (SLV_IDX_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_slv     (req_slv),
        .req_tx_data (req_tx_data),
        .gnt         (gnt),
        .done        (done),
        .err         (err),
        .rsp_rx_data (rsp_rx_data),
        .m_start     (m_start),
        .m_tx_data   (m_tx_data),
        .m_ss_sel    (m_ss_sel),
        .m_busy      (m_busy),
        .m_irq       (m_irq),
        .m_rx_data   (m_rx_data)
    );

    always #5 clk = ~clk;

    // Master model: busy rises busy_delay cycles after start, irq pulses irq_delay cycles after start.
    always @(negedge clk) begin
        m_irq = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_busy   = 1'b0;
            m_cnt    = 0;
        end else if (m_start) begin
            m_active = !never_busy;
            m_cnt    = 0;
            start_count++;
        end else if (m_active) begin
            m_cnt++;
            if (m_cnt == busy_delay) m_busy = 1'b1;
            if (m_cnt == irq_delay) begin
                m_irq     = 1'b1;
                m_busy    = 1'b0;
                m_rx_data = rx_word;
                m_active  = 1'b0;
            end
        end
        if ($countones(gnt) > 1 || (m_start && $countones(gnt) != 1)) gnt_faults++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] r);
        req = r;
    endtask

    task automatic setPayload(input int i, input logic [SLV_IDX_W-1:0] slv, input logic [31:0] tx);
        req_slv[i*SLV_IDX_W +: SLV_IDX_W]      = slv;
        req_tx_data[i*DATA_WIDTH +: DATA_WIDTH] = tx;
    endtask

    task automatic waitStart(output int cycles);
        cycles = 0;
        while (!m_start && cycles < 100) begin
            stepCycle();
            cycles++;
        end
        if (!m_start) checkOutput("start_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (done == '0 && cycles < 100) begin
            stepCycle();
            cycles++;
        end
        if (done == '0) checkOutput("done_wait_expired", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        $display("[TB] start");
        for (int i = 0; i < NUM_REQ; i++) setPayload(i, SLV_IDX_W'(i), 32'h1000_0000 * (i + 1));
        repeat (3) stepCycle();
        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        checkOutput("rst_start", 32'(m_start), 32'h0);
        checkOutput("rst_ss", 32'(m_ss_sel), 32'h0);
        checkOutput("rst_tx", m_tx_data, 32'h0);
        checkOutput("rst_rx", rsp_rx_data, 32'h0);
        rst = 1'b0;
        repeat (2) stepCycle();

        // Contention: all four requesting, grants rotate 0,1,2,3 twice.
        busy_delay = 3;
        irq_delay  = 6;
        begin
            int s0 = start_count;
            applyStimulus(4'b1111);
            for (int k = 0; k < 8; k++) begin
                rx_word = 32'h5000_0000 + k;
                waitStart(cyc);
                checkOutput($sformatf("cont_gnt%0d", k), 32'(gnt), 32'(1) << (k % 4));
                checkOutput($sformatf("cont_tx%0d", k), m_tx_data, 32'h1000_0000 * ((k % 4) + 1));
                checkOutput($sformatf("cont_ss%0d", k), 32'(m_ss_sel), 32'(1) << (k % 4));
                waitDone(cyc);
                checkOutput($sformatf("cont_done%0d", k), 32'(done), 32'(1) << (k % 4));
                checkOutput($sformatf("cont_rx%0d", k), rsp_rx_data, 32'h5000_0000 + k);
            end
            applyStimulus(4'b0000);
            checkOutput("cont_starts", 32'(start_count - s0), 32'd8);
            checkOutput("cont_gnt_faults", 32'(gnt_faults), 32'd0);
        end

        // Single requester, rr_ptr back at 0.
        repeat (2) stepCycle();
        setPayload(0, 3'd2, 32'hA5A5_0001);
        busy_delay = 3;
        irq_delay  = 14;
        rx_word    = 32'h1234_5678;
        applyStimulus(4'b0001);
        stepCycle();
        checkOutput("t1_start", 32'(m_start), 32'h1);
        checkOutput("t1_gnt", 32'(gnt), 32'h1);
        checkOutput("t1_ss", 32'(m_ss_sel), 32'b0100);
        checkOutput("t1_tx", m_tx_data, 32'hA5A5_0001);
        stepCycle();
        checkOutput("t1_start_width", 32'(m_start), 32'h0);
        waitDone(cyc);
        checkOutput("t1_latency", 32'(cyc + 1), 32'd15);
        checkOutput("t1_done", 32'(done), 32'h1);
        checkOutput("t1_err", 32'(err), 32'h0);
        checkOutput("t1_rx", rsp_rx_data, 32'h1234_5678);
        applyStimulus(4'b0000);
        stepCycle();
        checkOutput("t1_done_width", 32'(done), 32'h0);
        checkOutput("t1_gnt_clear", 32'(gnt), 32'h0);
        checkOutput("t1_rx_hold", rsp_rx_data, 32'h1234_5678);

        // Busy never rises: watchdog abort 17 cycles after start.
        repeat (2) stepCycle();
        setPayload(1, 3'd1, 32'hA5A5_0002);
        never_busy = 1'b1;
        applyStimulus(4'b0010);
        stepCycle();
        checkOutput("to_start", 32'(m_start), 32'h1);
        checkOutput("to_gnt", 32'(gnt), 32'b0010);
        waitDone(cyc);
        checkOutput("to_latency", 32'(cyc), 32'd17);
        checkOutput("to_done", 32'(done), 32'b0010);
        checkOutput("to_err", 32'(err), 32'b0010);
        checkOutput("to_rx", rsp_rx_data, 32'h0);
        applyStimulus(4'b0000);
        never_busy = 1'b0;

        // Next request after the abort is serviced normally.
        repeat (2) stepCycle();
        setPayload(2, 3'd3, 32'hA5A5_0003);
        irq_delay = 6;
        rx_word   = 32'hCAFE_F00D;
        applyStimulus(4'b0100);
        stepCycle();
        checkOutput("post_to_gnt", 32'(gnt), 32'b0100);
        checkOutput("post_to_ss", 32'(m_ss_sel), 32'b1000);
        waitDone(cyc);
        checkOutput("post_to_done", 32'(done), 32'b0100);
        checkOutput("post_to_err", 32'(err), 32'h0);
        checkOutput("post_to_rx", rsp_rx_data, 32'hCAFE_F00D);
        applyStimulus(4'b0000);

        // Slave index 7 with only four slaves: no start, abort two cycles after req.
        repeat (2) stepCycle();
        setPayload(1, 3'd7, 32'hA5A5_0004);
        applyStimulus(4'b0010);
        stepCycle();
        checkOutput("bad_gnt", 32'(gnt), 32'b0010);
        checkOutput("bad_start", 32'(m_start), 32'h0);
        checkOutput("bad_ss", 32'(m_ss_sel), 32'h0);
        stepCycle();
        checkOutput("bad_done", 32'(done), 32'b0010);
        checkOutput("bad_err", 32'(err), 32'b0010);
        applyStimulus(4'b0000);
        setPayload(1, 3'd1, 32'hA5A5_0002);

        // rr_ptr should now be 2.
        repeat (2) stepCycle();
        applyStimulus(4'b1111);
        stepCycle();
        checkOutput("bad_rr_gnt", 32'(gnt), 32'b0100);
        checkOutput("bad_rr_start", 32'(m_start), 32'h1);
        waitDone(cyc);
        applyStimulus(4'b0000);

        // Requester 2 withdraws mid-transfer; done still arrives.
        repeat (2) stepCycle();
        irq_delay = 10;
        rx_word   = 32'h0000_BEEF;
        applyStimulus(4'b0100);
        stepCycle();
        checkOutput("wd_gnt", 32'(gnt), 32'b0100);
        repeat (6) stepCycle();
        applyStimulus(4'b0000);
        waitDone(cyc);
        checkOutput("wd_done", 32'(done), 32'b0100);
        checkOutput("wd_gnt_in_resp", 32'(gnt), 32'b0100);
        checkOutput("wd_rx", rsp_rx_data, 32'h0000_BEEF);
        stepCycle();
        checkOutput("wd_gnt_drop", 32'(gnt), 32'h0);

        // Reset during WAIT_DONE.
        repeat (2) stepCycle();
        irq_delay = 14;
        applyStimulus(4'b0010);
        stepCycle();
        checkOutput("mr_gnt", 32'(gnt), 32'b0010);
        repeat (5) stepCycle();
        rst = 1'b1;
        applyStimulus(4'b0000);
        stepCycle();
        checkOutput("mr_gnt_clr", 32'(gnt), 32'h0);
        checkOutput("mr_done_clr", 32'(done), 32'h0);
        checkOutput("mr_err_clr", 32'(err), 32'h0);
        checkOutput("mr_start_clr", 32'(m_start), 32'h0);
        checkOutput("mr_ss_clr", 32'(m_ss_sel), 32'h0);
        checkOutput("mr_tx_clr", m_tx_data, 32'h0);
        checkOutput("mr_rx_clr", rsp_rx_data, 32'h0);
        rst = 1'b0;
        stepCycle();
        checkOutput("mr_no_done", 32'(done), 32'h0);
        irq_delay = 6;
        rx_word   = 32'h0BAD_CAFE;
        applyStimulus(4'b1100);
        stepCycle();
        checkOutput("mr_rr_gnt", 32'(gnt), 32'b0100);
        waitDone(cyc);
        checkOutput("mr_rr_done", 32'(done), 32'b0100);
        checkOutput("mr_rr_rx", rsp_rx_data, 32'h0BAD_CAFE);
        applyStimulus(4'b0000);
        repeat (2) stepCycle();

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
